// File: rtl/ycc2rgb_stream.sv
// Purpose : YCrCb -> RGB colour-space converter, BT.601/BT.709 selectable per pixel, clamped output.
// Latency : 3 cycles from input transfer to out_valid; 1 pixel/clk throughput.
// Backpr. : stallable valid/ready pipeline, bubbles collapse, up to 3 pixels held while out_ready=0.
//
// Ports   : clk/rst (async active-high); in_valid/in_ready + in_y/in_cr/in_cb/in_mode/in_user;
//           out_valid/out_ready + out_r/out_g/out_b/out_user (all outputs registered).
// Option  : define YCC2RGB_ROUND_EN for round-half-up before the clamp (default: truncation).
module ycc2rgb_stream #(
    parameter int IN_W   = 10,
    parameter int OUT_W  = 8,
    parameter int FRAC_W = 8,
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_y,
    input  logic [IN_W-1:0]   in_cr,
    input  logic [IN_W-1:0]   in_cb,
    input  logic              in_mode,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_r,
    output logic [OUT_W-1:0]  out_g,
    output logic [OUT_W-1:0]  out_b,
    output logic [USER_W-1:0] out_user
);

    localparam int DW    = IN_W + 1;            // signed offset-removed sample
    localparam int KW    = FRAC_W + 3;          // unsigned Q2.FRAC_W plus a sign bit
    localparam int PW    = DW + KW;             // product width
    localparam int SW    = PW + 2;              // sum width with 2 guard bits
    localparam int SH    = FRAC_W + IN_W - OUT_W;
    localparam int Y_OFS = (IN_W >= 10) ? (64 << (IN_W - 10)) : (64 >> (10 - IN_W));
    localparam int C_OFS = 1 << (IN_W - 1);
    localparam logic signed [SW-1:0] OMAX = SW'((1 << OUT_W) - 1);
`ifdef YCC2RGB_ROUND_EN
    localparam logic signed [SW-1:0] RND  = SW'(1 << (SH - 1));
`endif

    // Coefficients are tabulated at 8 fractional bits and rescaled to FRAC_W.
    function automatic logic signed [PW-1:0] kc(input int k);
        int s;
        s = (FRAC_W >= 8) ? (k << (FRAC_W - 8)) : (k >> (8 - FRAC_W));
        return PW'(s);
    endfunction

    function automatic logic [OUT_W-1:0] clamp(input logic signed [SW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > OMAX)
            return '1;
        else
            return v[OUT_W-1:0];
    endfunction

    // Stage 1 state
    logic                     v1_q, v1_d;
    logic signed [DW-1:0]     yd_q, yd_d, crd_q, crd_d, cbd_q, cbd_d;
    logic                     mode1_q, mode1_d;
    logic [USER_W-1:0]        user1_q, user1_d;
    // Stage 2 state
    logic                     v2_q, v2_d;
    logic signed [PW-1:0]     x_q, x_d, a_q, a_d, b1_q, b1_d, b2_q, b2_d, c_q, c_d;
    logic [USER_W-1:0]        user2_q, user2_d;
    // Stage 3 state (drives the outputs directly)
    logic                     v3_q, v3_d;
    logic [OUT_W-1:0]         r_q, r_d, g_q, g_d, b_q, b_d;
    logic [USER_W-1:0]        user3_q, user3_d;

    logic                     ld1, ld2, ld3;
    logic signed [PW-1:0]     k1, k2, k3, k4, k5;
    logic signed [SW-1:0]     sum_r, sum_g, sum_b;

    // A stage loads when it is empty or its contents move on this cycle.
    assign ld3      = !v3_q || out_ready;
    assign ld2      = !v2_q || ld3;
    assign ld1      = !v1_q || ld2;
    assign in_ready = ld1;

    // Coefficient ROM indexed by the mode captured with this pixel.
    always_comb begin
        if (mode1_q) begin
            k1 = kc(298); k2 = kc(459); k3 = kc(55);  k4 = kc(136); k5 = kc(541);
        end else begin
            k1 = kc(298); k2 = kc(409); k3 = kc(208); k4 = kc(100); k5 = kc(516);
        end
    end

    always_comb begin
        sum_r = SW'(x_q) + SW'(a_q);
        sum_g = SW'(x_q) - SW'(b1_q) - SW'(b2_q);
        sum_b = SW'(x_q) + SW'(c_q);
`ifdef YCC2RGB_ROUND_EN
        sum_r = sum_r + RND;
        sum_g = sum_g + RND;
        sum_b = sum_b + RND;
`endif
    end

    always_comb begin
        v1_d = v1_q; yd_d = yd_q; crd_d = crd_q; cbd_d = cbd_q;
        mode1_d = mode1_q; user1_d = user1_q;
        v2_d = v2_q; x_d = x_q; a_d = a_q; b1_d = b1_q; b2_d = b2_q; c_d = c_q;
        user2_d = user2_q;
        v3_d = v3_q; r_d = r_q; g_d = g_q; b_d = b_q; user3_d = user3_q;

        // Data registers only capture real pixels so held/idle stages never toggle.
        if (ld1) begin
            v1_d = in_valid;
            if (in_valid) begin
                yd_d    = $signed({1'b0, in_y})  - DW'(Y_OFS);
                crd_d   = $signed({1'b0, in_cr}) - DW'(C_OFS);
                cbd_d   = $signed({1'b0, in_cb}) - DW'(C_OFS);
                mode1_d = in_mode;
                user1_d = in_user;
            end
        end
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
                x_d     = PW'(yd_q)  * k1;
                a_d     = PW'(crd_q) * k2;
                b1_d    = PW'(crd_q) * k3;
                b2_d    = PW'(cbd_q) * k4;
                c_d     = PW'(cbd_q) * k5;
                user2_d = user1_q;
            end
        end
        if (ld3) begin
            v3_d = v2_q;
            if (v2_q) begin
                r_d     = clamp(sum_r >>> SH);
                g_d     = clamp(sum_g >>> SH);
                b_d     = clamp(sum_b >>> SH);
                user3_d = user2_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0; yd_q <= '0; crd_q <= '0; cbd_q <= '0; mode1_q <= 1'b0; user1_q <= '0;
            v2_q <= 1'b0; x_q <= '0; a_q <= '0; b1_q <= '0; b2_q <= '0; c_q <= '0; user2_q <= '0;
            v3_q <= 1'b0; r_q <= '0; g_q <= '0; b_q <= '0; user3_q <= '0;
        end else begin
            v1_q <= v1_d; yd_q <= yd_d; crd_q <= crd_d; cbd_q <= cbd_d;
            mode1_q <= mode1_d; user1_q <= user1_d;
            v2_q <= v2_d; x_q <= x_d; a_q <= a_d; b1_q <= b1_d; b2_q <= b2_d; c_q <= c_d;
            user2_q <= user2_d;
            v3_q <= v3_d; r_q <= r_d; g_q <= g_d; b_q <= b_d; user3_q <= user3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_r     = r_q;
    assign out_g     = g_q;
    assign out_b     = b_q;
    assign out_user  = user3_q;

endmodule

// File: tb/tb_ycc2rgb_stream.sv
// Purpose : directed self-checking bench for ycc2rgb_stream with an expected-pixel queue.
// Latency : checks the 3-cycle input-to-output latency on unstalled pixels.
// Backpr. : exercises an out_ready stall window, hold stability, and mid-stream reset.
module tb_ycc2rgb_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [9:0] in_y, in_cr, in_cb;
    logic [1:0] in_user, out_user;
    logic [7:0] out_r, out_g, out_b;

    ycc2rgb_stream dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_cr(in_cr), .in_cb(in_cb), .in_mode(in_mode), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_user(out_user)
    );

    always #5 clk = ~clk;

    // Vector table: Y, Cr, Cb, mode and hand-computed RGB.
    localparam int VY[5] = '{64, 940, 940, 64, 64};
    localparam int VR[5] = '{512, 512, 960, 64, 512};
    localparam int VB[5] = '{512, 512, 512, 512, 960};
    localparam int VM[5] = '{0, 0, 0, 0, 1};
`ifdef YCC2RGB_ROUND_EN
    localparam int ER[5] = '{0, 255, 255, 0, 0};
    localparam int EG[5] = '{0, 255, 164, 91, 0};
    localparam int EB[5] = '{0, 255, 255, 0, 237};
`else
    localparam int ER[5] = '{0, 254, 255, 0, 0};
    localparam int EG[5] = '{0, 254, 163, 91, 0};
    localparam int EB[5] = '{0, 254, 254, 0, 236};
`endif

    typedef struct {
        int r; int g; int b; int u; int acc; bit lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_emit = 0;
    int   e_r, e_g, e_b, e_u;
    bit   e_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: transfers are decided by the values present at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        exp_t ne;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_r", out_r, e.r);
                    check("out_g", out_g, e.g);
                    check("out_b", out_b, e.b);
                    check("out_user", out_user, e.u);
                    if (e.lat) check("latency", cyc - e.acc, 3);
                    last_emit = cyc;
                end
            end else if (out_valid && q.size() > 0) begin
                check("stall_r", out_r, q[0].r);
                check("stall_g", out_g, q[0].g);
                check("stall_b", out_b, q[0].b);
                check("stall_user", out_user, q[0].u);
            end
            if (in_valid && in_ready) begin
                ne.r = e_r; ne.g = e_g; ne.b = e_b; ne.u = e_u; ne.acc = cyc; ne.lat = e_lat;
                q.push_back(ne);
            end
        end
    end

    task automatic set_pix(input int idx, input int u, input bit lat);
        in_y    = 10'(VY[idx]);
        in_cr   = 10'(VR[idx]);
        in_cb   = 10'(VB[idx]);
        in_mode = VM[idx][0];
        in_user = 2'(u);
        e_r = ER[idx]; e_g = EG[idx]; e_b = EB[idx]; e_u = u; e_lat = lat;
        in_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_y     = 10'($urandom);
        in_cr    = 10'($urandom);
        in_cb    = 10'($urandom);
        in_mode  = 1'($urandom);
        in_user  = 2'($urandom);
    endtask

    task automatic send(input int idx, input int u, input bit lat);
        bit fired;
        fired = 1'b0;
        set_pix(idx, u, lat);
        for (int t = 0; t < 20 && !fired; t++) begin
            @(negedge clk);
            fired = in_ready;
            @(posedge clk); #1;
        end
        if (!fired) check("send_timeout", 0, 1);
        idle_inputs();
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && q.size() > 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, low_cnt, first_acc;
        bit held_chk;
        idle_inputs();
        out_ready = 1'b1;
        e_r = 0; e_g = 0; e_b = 0; e_u = 0; e_lat = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_r", out_r, 0);
        check("rst_out_user", out_user, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        // Black, white, clamp-high and clamp-low pixels (BT.601)
        send(0, 0, 1); drain();
        send(1, 1, 1); drain();
        send(2, 2, 1); send(3, 3, 1); drain();

        // Per-pixel mode switching: 601, 709, 601 back to back
        send(2, 1, 1); send(4, 2, 1); send(3, 0, 1); drain();
        repeat (3) @(posedge clk);
        #1;

        // 10-pixel stream with out_ready low on cycles 4..8
        sent = 0; low_cnt = 0; first_acc = 0; held_chk = 1'b0;
        for (int c = 0; c < 40 && sent < 10; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            set_pix(sent % 5, sent % 4, 1'b0);
            @(negedge clk);
            if (in_ready) begin
                if (sent == 0) first_acc = cyc;
                sent++;
            end else begin
                low_cnt++;
                if (!held_chk) begin
                    held_chk = 1'b1;
                    check("held_pixels", q.size(), 3);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        out_ready = 1'b1;
        drain();
        check("stream_sent", sent, 10);
        check("in_ready_low_cycles", low_cnt, 5);
        check("stream_span", last_emit - first_acc, 17);

        // Mid-stream reset with 3 pixels in flight
        out_ready = 1'b0;
        send(1, 1, 0); send(2, 2, 0); send(3, 3, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_r", out_r, 0);
        check("mid_rst_out_g", out_g, 0);
        check("mid_rst_out_b", out_b, 0);
        check("mid_rst_out_user", out_user, 0);
        check("mid_rst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(4, 3, 1);
        drain();
        repeat (10) @(posedge clk);
        #1;
        check("final_idle_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
